// File: rtl/yc_std_switch_ctrl_pkg.sv
// Shared definitions for the Y/C standard switch controller: FSM encoding,
// conversion standard codes and the black / neutral-chroma levels.
package yc_std_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_MUTE    = 2'd2
  } state_e;

  typedef logic [1:0] std_t;

  localparam std_t STD_BT601  = 2'd0;
  localparam std_t STD_BT709  = 2'd1;
  localparam std_t STD_BT2020 = 2'd2;
  localparam std_t STD_RSVD   = 2'd3;

  localparam int Y_BLACK_8B   = 64;
  localparam int C_NEUTRAL_10B = 512;

  // Black level scaled from its 8-bit definition to the sample width.
  function automatic int y_black(int w);
    return (w >= 8) ? (Y_BLACK_8B << (w - 8)) : (Y_BLACK_8B >> (8 - w));
  endfunction

  // Neutral chroma scaled from its 10-bit definition to the sample width.
  function automatic int c_neutral(int w);
    return (w >= 10) ? (C_NEUTRAL_10B << (w - 10)) : (C_NEUTRAL_10B >> (10 - w));
  endfunction

endpackage

// File: rtl/yc_std_switch_ctrl_if.sv
// Request/status handshake plus the sync and Y/C sample bus around the
// switch controller. slave = controller side, master = driver side.
interface yc_std_switch_ctrl_if
  import yc_std_switch_ctrl_pkg::*;
#(
  parameter int C_DATA_WIDTH = 10
);
  logic                    std_req;
  std_t                    std_new;
  logic                    VS_in;
  logic                    HS_in;
  logic                    DE_in;
  logic [C_DATA_WIDTH-1:0] Y_in;
  logic [C_DATA_WIDTH-1:0] C_in;

  std_t                    convert_std;
  logic                    std_busy;
  logic                    std_done;
  logic                    std_err;
  logic                    std_timeout;
  logic                    VS_out;
  logic                    HS_out;
  logic                    DE_out;
  logic [C_DATA_WIDTH-1:0] Y_out;
  logic [C_DATA_WIDTH-1:0] C_out;

  modport slave (
    input  std_req, std_new, VS_in, HS_in, DE_in, Y_in, C_in,
    output convert_std, std_busy, std_done, std_err, std_timeout,
           VS_out, HS_out, DE_out, Y_out, C_out
  );

  modport master (
    output std_req, std_new, VS_in, HS_in, DE_in, Y_in, C_in,
    input  convert_std, std_busy, std_done, std_err, std_timeout,
           VS_out, HS_out, DE_out, Y_out, C_out
  );

endinterface

// File: rtl/yc_mute_stage.sv
// One-cycle register stage for sync and Y/C samples; samples are replaced by
// black / neutral chroma while mute is high, sync always passes through.
module yc_mute_stage
  import yc_std_switch_ctrl_pkg::*;
#(
  parameter int C_DATA_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mute,
  input  logic                    vs_in,
  input  logic                    hs_in,
  input  logic                    de_in,
  input  logic [C_DATA_WIDTH-1:0] y_in,
  input  logic [C_DATA_WIDTH-1:0] c_in,
  output logic                    vs_out,
  output logic                    hs_out,
  output logic                    de_out,
  output logic [C_DATA_WIDTH-1:0] y_out,
  output logic [C_DATA_WIDTH-1:0] c_out
);

  localparam logic [C_DATA_WIDTH-1:0] Y_BLK = C_DATA_WIDTH'(y_black(C_DATA_WIDTH));
  localparam logic [C_DATA_WIDTH-1:0] C_NEU = C_DATA_WIDTH'(c_neutral(C_DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_out <= 1'b0;
      hs_out <= 1'b0;
      de_out <= 1'b0;
      y_out  <= '0;
      c_out  <= '0;
    end else begin
      vs_out <= vs_in;
      hs_out <= hs_in;
      de_out <= de_in;
      y_out  <= mute ? Y_BLK : y_in;
      c_out  <= mute ? C_NEU : c_in;
    end
  end

endmodule

// File: rtl/yc_std_switch_ctrl.sv
// Conversion-standard switch controller: accepts a standard change request,
// applies it on the next frame start (or watchdog expiry) and mutes video
// for C_MUTE_FRAMES frames so the converter's transient is never shown.
module yc_std_switch_ctrl
  import yc_std_switch_ctrl_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 10,
  parameter int C_MUTE_FRAMES = 1,
  parameter int C_VS_TIMEOUT  = 4194304
) (
  input logic                 clk,
  input logic                 reset,
  yc_std_switch_ctrl_if.slave bus
);

  localparam int              WD_W      = $clog2(C_VS_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(C_VS_TIMEOUT - 1);
  localparam logic [3:0]      MUTE_INIT = 4'(C_MUTE_FRAMES);

  state_e          state, state_nx;
  std_t            pend_std, pend_nx;
  std_t            cur_std, cur_nx;
  logic [3:0]      mute_cnt, cnt_nx;
  logic [WD_W-1:0] wdog, wdog_nx;
  logic            vs_d;
  logic            vs_rise;
  logic            wd_hit;
  logic            done_nx, err_nx, tmo_nx;

  assign vs_rise = bus.VS_in & ~vs_d;
  assign wd_hit  = (wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      pend_std        <= STD_BT601;
      cur_std         <= STD_BT601;
      mute_cnt        <= '0;
      wdog            <= '0;
      vs_d            <= 1'b0;
      bus.std_done    <= 1'b0;
      bus.std_err     <= 1'b0;
      bus.std_timeout <= 1'b0;
    end else begin
      state           <= state_nx;
      pend_std        <= pend_nx;
      cur_std         <= cur_nx;
      mute_cnt        <= cnt_nx;
      wdog            <= wdog_nx;
      vs_d            <= bus.VS_in;
      bus.std_done    <= done_nx;
      bus.std_err     <= err_nx;
      bus.std_timeout <= tmo_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend_std;
    cur_nx   = cur_std;
    cnt_nx   = mute_cnt;
    wdog_nx  = '0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    tmo_nx   = 1'b0;
    case (state)
      // VS is deliberately ignored here: a rise coincident with an accepted
      // request must not be taken as the switch point.
      ST_IDLE: begin
        if (bus.std_req) begin
          if (bus.std_new == STD_RSVD) begin
            err_nx = 1'b1;
          end else if (bus.std_new == cur_std) begin
            done_nx = 1'b1;
          end else begin
            pend_nx  = bus.std_new;
            state_nx = ST_WAIT_VS;
          end
        end
      end
      ST_WAIT_VS: begin
        err_nx  = bus.std_req;
        wdog_nx = wdog + 1'b1;
        if (vs_rise || wd_hit) begin
          cur_nx  = pend_std;
          cnt_nx  = MUTE_INIT;
          tmo_nx  = ~vs_rise;
          wdog_nx = '0;
          if (MUTE_INIT == 4'd0) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_MUTE;
          end
        end
      end
      ST_MUTE: begin
        err_nx = bus.std_req;
        if (vs_rise) begin
          cnt_nx = mute_cnt - 4'd1;
          if (mute_cnt <= 4'd1) begin
            cnt_nx   = '0;
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.convert_std = cur_std;
  assign bus.std_busy    = (state != ST_IDLE);

  yc_mute_stage #(
    .C_DATA_WIDTH(C_DATA_WIDTH)
  ) u_mute (
    .clk   (clk),
    .reset (reset),
    .mute  (state == ST_MUTE),
    .vs_in (bus.VS_in),
    .hs_in (bus.HS_in),
    .de_in (bus.DE_in),
    .y_in  (bus.Y_in),
    .c_in  (bus.C_in),
    .vs_out(bus.VS_out),
    .hs_out(bus.HS_out),
    .de_out(bus.DE_out),
    .y_out (bus.Y_out),
    .c_out (bus.C_out)
  );

endmodule

// File: tb/tb_yc_std_switch_ctrl.sv
// Directed bench: a per-cycle vector table on the default configuration plus
// hand-written watchdog / mute / reset sequences on a 2-frame, 100-cycle build.
module tb_yc_std_switch_ctrl;
  import yc_std_switch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  yc_std_switch_ctrl_if #(.C_DATA_WIDTH(10)) ia ();
  yc_std_switch_ctrl_if #(.C_DATA_WIDTH(10)) ib ();

  yc_std_switch_ctrl #(.C_DATA_WIDTH(10)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave)
  );

  yc_std_switch_ctrl #(.C_DATA_WIDTH(10), .C_MUTE_FRAMES(2), .C_VS_TIMEOUT(100)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [28:0] obs_a, obs_b;
  assign obs_a = {ia.convert_std, ia.std_busy, ia.std_done, ia.std_err, ia.std_timeout,
                  ia.VS_out, ia.HS_out, ia.DE_out, ia.Y_out, ia.C_out};
  assign obs_b = {ib.convert_std, ib.std_busy, ib.std_done, ib.std_err, ib.std_timeout,
                  ib.VS_out, ib.HS_out, ib.DE_out, ib.Y_out, ib.C_out};

  typedef struct {
    logic       req;
    logic [1:0] nw;
    logic       vs;
    logic [1:0] e_cs;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
    logic       e_mute;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic req, logic [1:0] nw, logic vs, logic [1:0] cs,
                              logic busy, logic done, logic err, logic mute);
    vec_t v;
    v.req = req; v.nw = nw; v.vs = vs; v.e_cs = cs;
    v.e_busy = busy; v.e_done = done; v.e_err = err; v.e_mute = mute;
    return v;
  endfunction

  function automatic logic [28:0] exp_o(logic [1:0] cs, logic busy, logic done, logic err,
                                        logic tmo, logic vs, logic hs, logic de,
                                        logic [9:0] y, logic [9:0] c);
    return {cs, busy, done, err, tmo, vs, hs, de, y, c};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ia.std_req = 1'b0; ia.std_new = 2'd0; ia.VS_in = 1'b0; ia.HS_in = 1'b0; ia.DE_in = 1'b0;
    ia.Y_in = 10'd0; ia.C_in = 10'd300;
    ib.std_req = 1'b0; ib.std_new = 2'd0; ib.VS_in = 1'b0; ib.HS_in = 1'b0; ib.DE_in = 1'b0;
    ib.Y_in = 10'd400; ib.C_in = 10'd100;
  endtask

  initial begin
    logic [9:0] yv;
    logic       bad;

    //              req nw vs  cs busy done err mute
    tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 0,  0, 0, 0, 1, 0);  // reserved -> err
    tbl[2]  = mk(0, 0, 0,  0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0,  0, 0, 1, 0, 0);  // same std -> done
    tbl[4]  = mk(0, 0, 0,  0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1,  0, 1, 0, 0, 0);  // accept on a VS rise: no switch
    tbl[6]  = mk(0, 0, 1,  0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,  0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 2, 0,  0, 1, 0, 1, 0);  // busy -> err, pend unchanged
    tbl[9]  = mk(0, 0, 1,  1, 1, 0, 0, 0);  // switch edge
    tbl[10] = mk(0, 0, 0,  1, 1, 0, 0, 1);
    tbl[11] = mk(1, 0, 0,  1, 1, 0, 1, 1);  // request while muting -> err
    tbl[12] = mk(0, 0, 1,  1, 0, 1, 0, 1);  // frame end -> done
    tbl[13] = mk(0, 0, 0,  1, 0, 0, 0, 0);  // unmuted
    tbl[14] = mk(1, 1, 0,  1, 0, 1, 0, 0);
    tbl[15] = mk(0, 0, 0,  1, 0, 0, 0, 0);

    // reset with busy-looking inputs: every output must still be zero
    idle_inputs();
    ia.VS_in = 1'b1; ia.HS_in = 1'b1; ia.DE_in = 1'b1; ia.Y_in = 10'd5; ia.C_in = 10'd7;
    ib.VS_in = 1'b1; ib.HS_in = 1'b1; ib.DE_in = 1'b1; ib.Y_in = 10'd5; ib.C_in = 10'd7;
    step(); step();
    chk("reset_a", 32'(obs_a), 32'd0);
    chk("reset_b", 32'(obs_b), 32'd0);
    idle_inputs();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      yv = 10'(100 + i);
      ia.std_req = tbl[i].req;
      ia.std_new = tbl[i].nw;
      ia.VS_in   = tbl[i].vs;
      ia.HS_in   = ~tbl[i].vs;
      ia.Y_in    = yv;
      ia.DE_in   = yv[0];
      step();
      chk($sformatf("vec%0d", i), 32'(obs_a),
          32'(exp_o(tbl[i].e_cs, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err, 1'b0,
                    tbl[i].vs, ~tbl[i].vs, yv[0],
                    tbl[i].e_mute ? 10'd256 : yv, tbl[i].e_mute ? 10'd512 : 10'd300)));
    end

    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_cs_a", 32'(ia.convert_std), 32'd0);

    // basic switch: VS rise 1000 cycles after the request
    ia.std_req = 1'b1; ia.std_new = 2'd1;
    step();
    ia.std_req = 1'b0;
    chk("basic_busy", 32'({ia.std_busy, ia.convert_std}), 32'({1'b1, 2'd0}));
    bad = 1'b0;
    repeat (999) begin
      step();
      if (ia.convert_std !== 2'd0 || ia.std_done !== 1'b0 || ia.std_busy !== 1'b1) bad = 1'b1;
    end
    chk("basic_wait_quiet", 32'(bad), 32'd0);
    ia.VS_in = 1'b1;
    step();
    chk("basic_switch", 32'({ia.convert_std, ia.std_busy, ia.std_done}), 32'({2'd1, 1'b1, 1'b0}));
    ia.VS_in = 1'b0; ia.Y_in = 10'd123;
    step();
    chk("basic_muted", 32'({ia.Y_out, ia.C_out}), 32'({10'd256, 10'd512}));
    bad = 1'b0;
    repeat (40) begin
      step();
      if (ia.Y_out !== 10'd256 || ia.std_done !== 1'b0) bad = 1'b1;
    end
    chk("basic_frame_muted", 32'(bad), 32'd0);
    ia.VS_in = 1'b1;
    step();
    chk("basic_done", 32'({ia.std_done, ia.std_busy}), 32'({1'b1, 1'b0}));
    ia.VS_in = 1'b0; ia.Y_in = 10'd77;
    step();
    chk("basic_unmute", 32'({ia.std_done, ia.Y_out, ia.C_out}), 32'({1'b0, 10'd77, 10'd300}));

    // watchdog: VS held low, switch exactly 100 cycles after entering WAIT_VS
    ib.std_req = 1'b1; ib.std_new = 2'd2;
    step();
    ib.std_req = 1'b0;
    chk("wd_busy", 32'(ib.std_busy), 32'd1);
    bad = 1'b0;
    repeat (99) begin
      step();
      if (ib.std_timeout !== 1'b0 || ib.convert_std !== 2'd0) bad = 1'b1;
    end
    chk("wd_early", 32'(bad), 32'd0);
    step();
    chk("wd_fire", 32'({ib.std_timeout, ib.convert_std, ib.std_busy, ib.std_done}),
        32'({1'b1, 2'd2, 1'b1, 1'b0}));
    step();
    chk("wd_pulse_end", 32'({ib.std_timeout, ib.Y_out, ib.C_out}), 32'({1'b0, 10'd256, 10'd512}));

    // two muted frames
    bad = 1'b0;
    repeat (9) begin
      step();
      if (ib.Y_out !== 10'd256 || ib.C_out !== 10'd512) bad = 1'b1;
    end
    chk("mute_frame1", 32'(bad), 32'd0);
    ib.VS_in = 1'b1;
    step();
    chk("mute_first_rise", 32'({ib.std_busy, ib.std_done, ib.Y_out}), 32'({1'b1, 1'b0, 10'd256}));
    ib.VS_in = 1'b0;
    bad = 1'b0;
    repeat (19) begin
      step();
      if (ib.Y_out !== 10'd256 || ib.C_out !== 10'd512 || ib.std_busy !== 1'b1) bad = 1'b1;
    end
    chk("mute_frame2", 32'(bad), 32'd0);
    ib.VS_in = 1'b1;
    step();
    chk("mute_done", 32'({ib.std_done, ib.std_busy, ib.Y_out}), 32'({1'b1, 1'b0, 10'd256}));
    ib.VS_in = 1'b0; ib.Y_in = 10'h155;
    step();
    chk("mute_release", 32'({ib.Y_out, ib.C_out, ib.VS_out}), 32'({10'h155, 10'd100, 1'b0}));
    ib.Y_in = 10'h2AA;
    step();
    chk("pass_latency", 32'(ib.Y_out), 32'h2AA);

    // reset while muting aborts without std_done
    ib.std_req = 1'b1; ib.std_new = 2'd1;
    step();
    ib.std_req = 1'b0;
    ib.VS_in = 1'b1;
    step();
    chk("rst_sw", 32'(ib.convert_std), 32'd1);
    ib.VS_in = 1'b0;
    step();
    chk("rst_muted", 32'(ib.Y_out), 32'd256);
    reset = 1'b1;
    ib.VS_in = 1'b1; ib.HS_in = 1'b1; ib.DE_in = 1'b1; ib.Y_in = 10'h3FF;
    step();
    chk("rst_in_mute", 32'(obs_b), 32'd0);
    reset = 1'b0;
    ib.std_req = 1'b1; ib.std_new = 2'd2;
    step();
    ib.std_req = 1'b0;
    chk("rst_accept", 32'({ib.std_busy, ib.std_done, ib.convert_std}), 32'({1'b1, 1'b0, 2'd0}));
    ib.VS_in = 1'b0;
    step();
    chk("rst_no_switch", 32'({ib.convert_std, ib.std_busy}), 32'({2'd0, 1'b1}));
    ib.VS_in = 1'b1;
    step();
    chk("rst_then_switch", 32'(ib.convert_std), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/yc_std_switch_ctrl.md
YC_STD_SWITCH_CTRL -- requirements
Module: yc_std_switch_ctrl

Interface
REQ-001 Parameter C_DATA_WIDTH, default 10, sets the Y/C sample width.
REQ-002 Parameter C_MUTE_FRAMES, default 1, sets the number of frames muted after a standard switch (range 0..15).
REQ-003 Parameter C_VS_TIMEOUT, default 4194304, sets the WAIT_VS watchdog limit in clk cycles.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 std_req  in  1  one-cycle request to change the conversion standard.
REQ-007 std_new  in  2  requested standard, sampled when std_req=1.
REQ-008 VS_in / HS_in / DE_in  in  1 each  sync signals from the converter output (VS active high).
REQ-009 Y_in / C_in  in  C_DATA_WIDTH each  converter output samples.
REQ-010 convert_std  out  2  standard driven to the converter's convert_std input.
REQ-011 std_busy  out  1  high while a request is pending or muting.
REQ-012 std_done  out  1  one-cycle pulse when a request completes.
REQ-013 std_err  out  1  one-cycle pulse when a request is rejected.
REQ-014 std_timeout  out  1  one-cycle pulse when the watchdog forces a switch.
REQ-015 VS_out / HS_out / DE_out  out  1 each  sync signals delayed by 1 cycle.
REQ-016 Y_out / C_out  out  C_DATA_WIDTH each  samples delayed by 1 cycle, blanked while muting.

Function
REQ-017 Frame start is a VS rise: VS_in=1 while the registered VS_in was 0.
REQ-018 The FSM shall have three states: IDLE, WAIT_VS and MUTE.
REQ-019 IDLE + std_req with std_new=3 → std_err next cycle; the state stays IDLE.
REQ-020 IDLE + std_req with std_new=convert_std → std_done next cycle; the state stays IDLE.
REQ-021 IDLE + std_req with any other valid value → latch pend_std and go to WAIT_VS; std_busy=1 from the next cycle.
REQ-022 std_req while in WAIT_VS or MUTE is ignored, raises std_err, and leaves pend_std unchanged.
REQ-023 A VS rise coincident with an accepted request is not a switch point; the controller waits for the next VS rise.
REQ-024 In WAIT_VS, on a VS rise: convert_std←pend_std and mute_cnt←C_MUTE_FRAMES on the same edge; go to MUTE, or to IDLE with std_done if C_MUTE_FRAMES=0.
REQ-025 WAIT_VS keeps a cycle counter; if it reaches C_VS_TIMEOUT, apply as REQ-024 and pulse std_timeout.
REQ-026 In MUTE, each VS rise decrements mute_cnt; the rise that makes it 0 moves the state to IDLE and pulses std_done.
REQ-027 While in MUTE, Y_out=64<<(C_DATA_WIDTH-8) and C_out=512<<(C_DATA_WIDTH-10) (black, neutral chroma); sync signals always pass unchanged.
REQ-028 Muting is evaluated on the registered state: the first muted sample is 1 cycle after the switch edge; unmute occurs 1 cycle after the IDLE transition.
REQ-029 std_busy=1 exactly when the state is WAIT_VS or MUTE.
REQ-030 Data path latency is exactly 1 cycle and has no back-pressure.
REQ-031 std_done, std_err and std_timeout are never high for 2 consecutive cycles.

Reset
REQ-032 On reset: state=IDLE, convert_std=0, pend_std=0, mute_cnt=0, watchdog=0, VS_d=0.
REQ-033 On reset: every output is 0 (std_busy/done/err/timeout, VS/HS/DE_out, Y_out, C_out).
REQ-034 Reset mid-operation aborts the pending switch with no std_done; the first cycle after reset, std_req is accepted normally.

Structure
REQ-035 A shared package holds the FSM state encoding, the standard codes (0=BT601, 1=BT709, 2=BT2020, 3=reserved) and the black/neutral constants.
REQ-036 The sync/sample delay-and-mute register stage is one sub-module, yc_mute_stage; the FSM, watchdog and edge detect stay in the top level.

Verification
REQ-037 Basic switch: std_req with std_new=1 at convert_std=0, VS rise 1000 cycles later → convert_std=1 on that edge, muted for 1 frame, std_done at the second VS rise.
REQ-038 Request on VS edge: std_req and a VS rise in the same cycle → no switch on that edge; convert_std changes only at the following VS rise.
REQ-039 Rejects: std_new=3, a second std_req while busy, and std_new equal to the current standard → std_err, std_err, and std_done respectively; convert_std unchanged in all three cases.
REQ-040 Watchdog: C_VS_TIMEOUT=100, VS held low → std_timeout and the convert_std update exactly 100 cycles after entering WAIT_VS.
REQ-041 Mute data: C_MUTE_FRAMES=2, C_DATA_WIDTH=10 → Y_out=256 and C_out=512 for 2 full frames, then Y_in passes through with 1-cycle latency.
REQ-042 Reset during MUTE → all outputs 0 next cycle, no std_done, convert_std=0.
